// File: rtl/isa_cycle_sequencer.sv
// ISA bus cycle sequencer: address latch, setup, strobe, optional iochrdy wait, hold, control reset.
// Optional feature macro: ISA_IOCHRDY_EN (iochrdy wait states and timeout).
module isa_cycle_sequencer #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 4,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] control_in,
    input  logic       iochrdy,
    output logic       address_load,
    output logic       data_load,
    output logic       iow,
    output logic       ior,
    output logic       memw,
    output logic       memr,
    output logic       control_reset,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_SETUP    = 3'd2,
        S_STROBE   = 3'd3,
        S_WAIT     = 3'd4,
        S_HOLD     = 3'd5,
        S_CTRL_RST = 3'd6
    } state_t;

    localparam logic [3:0] SETUP_LAST   = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST    = 4'(HOLD_CYC - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic       STROBE_ONE   = (STROBE_CYC == 1);

    state_t     r_state;
    logic [3:0] r_phase_cnt;
    logic [7:0] r_wait_cnt;
    logic       r_op_read;
    logic       r_space_mem;
    logic [3:0] r_strobe_n;
    logic       r_address_load;
    logic       r_data_load;
    logic       r_control_reset;
    logic       r_busy;
    logic       r_timeout;
    logic       r_rd_window;
    logic       w_ready;
    logic       w_unused;

    // Strobe vector bit order: 0 iow, 1 ior, 2 memw, 3 memr (active low)
    function automatic logic [3:0] strobe_sel(input logic rd, input logic mem);
        logic [3:0] v;
        v = 4'b1111;
        case ({mem, rd})
            2'b00:   v[0] = 1'b0;
            2'b01:   v[1] = 1'b0;
            2'b10:   v[2] = 1'b0;
            2'b11:   v[3] = 1'b0;
            default: v = 4'b1111;
        endcase
        return v;
    endfunction

`ifdef ISA_IOCHRDY_EN
    assign w_ready  = iochrdy;
    assign w_unused = ^control_in[7:3];
`else
    assign w_ready  = 1'b1;
    assign w_unused = ^{control_in[7:3], iochrdy};
`endif

    // Sequencer state, phase/wait counters and registered bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_phase_cnt     <= 4'd0;
            r_wait_cnt      <= 8'd0;
            r_op_read       <= 1'b0;
            r_space_mem     <= 1'b0;
            r_strobe_n      <= 4'b1111;
            r_address_load  <= 1'b1;
            r_data_load     <= 1'b1;
            r_control_reset <= 1'b1;
            r_busy          <= 1'b0;
            r_timeout       <= 1'b0;
            r_rd_window     <= 1'b0;
        end else begin
            r_address_load  <= 1'b1;
            r_data_load     <= 1'b1;
            r_control_reset <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (control_in[0] || control_in[1]) begin
                        r_state        <= S_ADDR;
                        r_op_read      <= control_in[0];
                        r_space_mem    <= control_in[2];
                        r_address_load <= 1'b0;
                        r_busy         <= 1'b1;
                        r_timeout      <= 1'b0;
                        r_phase_cnt    <= 4'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADDR: begin
                    r_state     <= S_SETUP;
                    r_phase_cnt <= 4'd0;
                    r_data_load <= r_op_read;
                end
                S_SETUP: begin
                    if (r_phase_cnt == SETUP_LAST) begin
                        r_state     <= S_STROBE;
                        r_phase_cnt <= 4'd0;
                        r_strobe_n  <= strobe_sel(r_op_read, r_space_mem);
                        r_rd_window <= r_op_read && STROBE_ONE;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 4'd1;
                    end
                end
                S_STROBE: begin
                    if (r_phase_cnt == STROBE_LAST) begin
                        r_phase_cnt <= 4'd0;
                        if (w_ready) begin
                            r_state     <= S_HOLD;
                            r_strobe_n  <= 4'b1111;
                            r_rd_window <= 1'b0;
                        end else begin
                            r_state     <= S_WAIT;
                            r_wait_cnt  <= 8'd0;
                            r_rd_window <= r_op_read;
                        end
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 4'd1;
                        r_rd_window <= r_op_read && ((r_phase_cnt + 4'd1) == STROBE_LAST);
                    end
                end
                S_WAIT: begin
                    if (w_ready) begin
                        r_state     <= S_HOLD;
                        r_phase_cnt <= 4'd0;
                        r_strobe_n  <= 4'b1111;
                        r_rd_window <= 1'b0;
                    end else if (r_wait_cnt == TIMEOUT_LAST) begin
                        // Give up on the target: release strobe without latching read data
                        r_state     <= S_HOLD;
                        r_phase_cnt <= 4'd0;
                        r_strobe_n  <= 4'b1111;
                        r_rd_window <= 1'b0;
                        r_timeout   <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (r_phase_cnt == HOLD_LAST) begin
                        r_state         <= S_CTRL_RST;
                        r_phase_cnt     <= 4'd0;
                        r_control_reset <= 1'b0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 4'd1;
                    end
                end
                S_CTRL_RST: begin
                    r_state     <= S_IDLE;
                    r_phase_cnt <= 4'd0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_phase_cnt <= 4'd0;
                    r_wait_cnt  <= 8'd0;
                    r_strobe_n  <= 4'b1111;
                    r_busy      <= 1'b0;
                    r_rd_window <= 1'b0;
                end
            endcase
        end
    end

    // Read data is latched in whichever strobe cycle the target reports ready
    assign data_load     = r_data_load & ~(r_rd_window & w_ready);
    assign address_load  = r_address_load;
    assign iow           = r_strobe_n[0];
    assign ior           = r_strobe_n[1];
    assign memw          = r_strobe_n[2];
    assign memr          = r_strobe_n[3];
    assign control_reset = r_control_reset;
    assign busy          = r_busy;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_isa_cycle_sequencer.sv
// Randomized scoreboard bench for isa_cycle_sequencer; works with or without ISA_IOCHRDY_EN.
module tb_isa_cycle_sequencer;

    localparam int SETUP  = 1;
    localparam int STROBE = 4;
    localparam int HOLD   = 1;
    localparam int TO     = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] control_in = 8'h00;
    logic       iochrdy = 1'b1;
    logic       address_load, data_load, iow, ior, memw, memr, control_reset, busy, timeout;

    int n_checks = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit in_txn = 1'b0;
    int idle_strobe_viol = 0;

    typedef struct {
        int strobe_idx;
        int strobe_len;
        int dl_idx;
        int busy_len;
        int to;
    } exp_t;

    exp_t sb[$];

    isa_cycle_sequencer #(
        .SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset), .control_in(control_in), .iochrdy(iochrdy),
        .address_load(address_load), .data_load(data_load), .iow(iow), .ior(ior),
        .memw(memw), .memr(memr), .control_reset(control_reset), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: strobe chosen by op/space, stretched by wait cycles up to the timeout limit
    function automatic exp_t model(input logic [7:0] ctrl, input int w);
        exp_t e;
        bit rd;
        rd = ctrl[0];
        e.strobe_idx = (ctrl[2] ? 2 : 0) + (rd ? 1 : 0);
`ifdef ISA_IOCHRDY_EN
        if (w <= TO) begin
            e.strobe_len = STROBE + w;
            e.to = 0;
        end else begin
            e.strobe_len = STROBE + TO;
            e.to = 1;
        end
`else
        e.strobe_len = STROBE;
        e.to = 0;
`endif
        if (!rd)       e.dl_idx = 2;
        else if (e.to) e.dl_idx = 0;
        else           e.dl_idx = 1 + SETUP + e.strobe_len;
        e.busy_len = 2 + SETUP + e.strobe_len + HOLD;
        return e;
    endfunction

    function automatic logic rdy_for(input int c, input int w);
        int j;
        j = c - (1 + SETUP);
        if (j >= STROBE && j - STROBE <= TO) return (j - STROBE == w);
        return 1'($urandom_range(1, 0));
    endfunction

    // Caller is one step after a rising edge with the DUT idle
    task automatic run_txn(input logic [7:0] ctrl, input int w, input int gap);
        exp_t e;
        e = model(ctrl, w);
        sb.push_back(e);
        control_in = ctrl;
        iochrdy = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
        for (int c = 1; c <= e.busy_len; c++) begin
            control_in = 8'($urandom);
            iochrdy = rdy_for(c, w);
            @(posedge clk); #1;
        end
        control_in = 8'h00;
        iochrdy = 1'($urandom_range(1, 0));
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: measure each busy window and compare with the next expected transaction
    initial begin : monitor
        int idx, n_addr, n_dl, dl_at, n_ctrl, ctrl_at, n_overlap, to_start;
        int slen[4];
        exp_t e;
        idx = 0; n_addr = 0; n_dl = 0; dl_at = 0; n_ctrl = 0; ctrl_at = 0;
        n_overlap = 0; to_start = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (busy) begin
                    if (!in_txn) begin
                        in_txn = 1'b1;
                        idx = 0; n_addr = 0; n_dl = 0; dl_at = 0; n_ctrl = 0; ctrl_at = 0;
                        n_overlap = 0;
                        for (int k = 0; k < 4; k++) slen[k] = 0;
                    end
                    idx++;
                    if (idx == 1) to_start = int'(timeout);
                    if (!address_load) n_addr += (idx == 1) ? 1 : 100;
                    if (!data_load) begin n_dl++; dl_at = idx; end
                    if (!control_reset) begin n_ctrl++; ctrl_at = idx; end
                    if (!iow)  slen[0]++;
                    if (!ior)  slen[1]++;
                    if (!memw) slen[2]++;
                    if (!memr) slen[3]++;
                    if ((4 - int'(iow) - int'(ior) - int'(memw) - int'(memr)) > 1) n_overlap++;
                end else begin
                    if (!(iow && ior && memw && memr && address_load && data_load && control_reset))
                        idle_strobe_viol++;
                    if (in_txn) begin
                        in_txn = 1'b0;
                        if (sb.size() == 0) begin
                            chk("unexpected_txn", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            for (int k = 0; k < 4; k++)
                                chk($sformatf("strobe%0d_len", k), slen[k],
                                    (k == e.strobe_idx) ? e.strobe_len : 0);
                            chk("addr_load_once_cycle1", n_addr, 1);
                            chk("data_load_count", n_dl, (e.dl_idx != 0) ? 1 : 0);
                            chk("data_load_cycle", dl_at, e.dl_idx);
                            chk("ctrl_reset_count", n_ctrl, 1);
                            chk("ctrl_reset_cycle", ctrl_at, e.busy_len);
                            chk("busy_len", idx, e.busy_len);
                            chk("strobe_overlap", n_overlap, 0);
                            chk("timeout_cleared_on_accept", to_start, 0);
                            chk("timeout_end", int'(timeout), e.to);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        int bound;
        #2 reset = 1'b0;
        #1;
        chk("rst_address_load", int'(address_load), 1);
        chk("rst_data_load", int'(data_load), 1);
        chk("rst_strobes", int'({iow, ior, memw, memr}), 15);
        chk("rst_control_reset", int'(control_reset), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the second strobe cycle of a read
        control_in = 8'h01; iochrdy = 1'b1;
        @(posedge clk); #1;
        control_in = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_strobe_ior_low", int'(ior), 0);
        reset = 1'b0;
        #1;
        chk("async_rst_strobes", int'({iow, ior, memw, memr}), 15);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_timeout", int'(timeout), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_restart_without_request", int'(busy), 0);

        mon_en = 1'b1;
        run_txn(8'h02, 0, 1);
        run_txn(8'h05, 0, 0);
        run_txn(8'h01, 3, 2);
        run_txn(8'h01, TO + 5, 0);
        run_txn(8'h03, 0, 1);
        run_txn(8'h06, TO, 0);
        run_txn(8'hFD, TO + 1, 0);
        run_txn(8'h0A, 1, 0);
        for (int n = 0; n < 30; n++) begin
            logic [7:0] c;
            c = 8'($urandom);
            if (c[1:0] == 2'b00) c[$urandom_range(1, 0)] = 1'b1;
            run_txn(c, int'($urandom_range(TO + 3, 0)), int'($urandom_range(2, 0)));
        end

        bound = 0;
        while ((sb.size() != 0 || in_txn) && bound < 2000) begin
            @(posedge clk);
            bound++;
        end
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("outputs_active_while_idle", idle_strobe_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/isa_cycle_sequencer.md
ISA_CYCLE_SEQUENCER -- requirements
Module: isa_cycle_sequencer

Interface
REQ-001 Parameter SETUP_CYC, 1, cycles between address_load and strobe assertion (legal 1..15).
REQ-002 Parameter STROBE_CYC, 4, minimum strobe-low cycles (legal 1..15).
REQ-003 Parameter HOLD_CYC, 1, strobe-high cycles after strobe release before control_reset (legal 1..15).
REQ-004 Parameter TIMEOUT_CYC, 255, maximum wait-state cycles beyond STROBE_CYC (legal 1..255).
REQ-005 Port clk  input  1  single clock; all state changes on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset.
REQ-007 Port control_in  input  8  bit0 read request, bit1 write request, bit2 space select (0 = I/O, 1 = memory), bits 7:3 ignored.
REQ-008 Port iochrdy  input  1  bus ready; 0 = target requests wait states.
REQ-009 Port address_load  output  1  active-low address latch enable.
REQ-010 Port data_load  output  1  active-low data latch enable.
REQ-011 Port iow, ior, memw, memr  output  1 each  active-low bus strobes.
REQ-012 Port control_reset  output  1  active-low one-cycle pulse clearing control_in source.
REQ-013 Port busy  output  1  high in every state except IDLE.
REQ-014 Port timeout  output  1  sticky flag, last cycle ended by wait timeout.

Function
REQ-015 States SHALL be IDLE, ADDR, SETUP, STROBE, WAIT, HOLD, CTRL_RST.
REQ-016 IDLE: bit0 or bit1 set -> ADDR, latching op (read if bit0 set, read wins when both set) and space (bit2); else stay.
REQ-017 Latched op/space SHALL NOT change until return to IDLE; control_in ignored outside IDLE.
REQ-018 ADDR: address_load=0 for exactly one cycle -> SETUP.
REQ-019 SETUP: SETUP_CYC cycles, no strobe asserted; write drives data_load=0 in first SETUP cycle only -> STROBE.
REQ-020 STROBE: selected strobe (iow/ior/memw/memr per op and space) low for STROBE_CYC cycles; all other strobes high.
REQ-021 End of STROBE: iochrdy=1 (or feature compiled out) -> HOLD; iochrdy=0 -> WAIT.
REQ-022 WAIT: strobe held low; iochrdy sampled 1 -> HOLD; wait counter reaching TIMEOUT_CYC -> HOLD with timeout set to 1.
REQ-023 Read data_load=0 exactly in final strobe-low cycle (last STROBE cycle with iochrdy=1, or WAIT cycle with iochrdy=1); no data_load on timeout.
REQ-024 HOLD: all strobes high for HOLD_CYC cycles -> CTRL_RST.
REQ-025 CTRL_RST: control_reset=0 for exactly one cycle -> IDLE.
REQ-026 Idle-to-idle latency without waits SHALL be 3+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (IDLE sample excluded).
REQ-027 At most one strobe SHALL be low in any cycle; strobes never low outside STROBE/WAIT.
REQ-028 timeout SHALL clear when the next request is accepted in IDLE.
REQ-029 Phase counters SHALL be 4 bits, wait counter 8 bits, both cleared on each state entry; no wrap-around permitted.

Reset
REQ-030 reset=0 SHALL force IDLE immediately, all active-low outputs to 1, busy=0, timeout=0, counters to 0, regardless of state.
REQ-031 Reset released mid-request SHALL start a fresh cycle only if control_in still requests one.

Configuration
REQ-032 Macro ISA_IOCHRDY_EN defined: iochrdy honoured, WAIT state and timeout active.
REQ-033 Macro ISA_IOCHRDY_EN undefined: iochrdy ignored, WAIT unreachable, timeout tied 0, strobe exactly STROBE_CYC cycles.

Verification (defaults, ISA_IOCHRDY_EN defined unless noted)
REQ-034 control_in=0x02, iochrdy=1 -> address_load=0 cycle 1, data_load=0 cycle 2, iow=0 cycles 3-6, control_reset=0 cycle 8, busy=0 cycle 9.
REQ-035 control_in=0x05 -> memr=0 cycles 3-6, data_load=0 cycle 6 only, ior/iow/memw stay 1.
REQ-036 control_in=0x01, iochrdy=0 until strobe cycle 7 -> ior=0 for 7 cycles, data_load=0 in 7th, timeout=0.
REQ-037 TIMEOUT_CYC=16, iochrdy stuck 0, read -> ior=0 for 20 cycles, timeout=1, no data_load, control_reset pulses; next request clears timeout.
REQ-038 control_in=0x03 -> read cycle (ior) performed, iow never asserted.
REQ-039 reset=0 during STROBE cycle 2 -> all strobes 1 and busy=0 without waiting for clk; macro undefined run of REQ-036 stimulus -> ior=0 exactly 4 cycles.
